// File: rtl/axis_out_capture.sv
// AXI-Stream capture sink: arm/disarm-gated circular buffer with beat/packet counters and a 1-cycle read port.
// Optional tkeep legality flag (keep_err) is built when AXIS_OUT_CAPTURE_KEEP_CHECK_EN is defined.
module axis_out_capture #(
    parameter int DATA_WIDTH_BYTES = 8,
    parameter int DEPTH            = 256,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [8*DATA_WIDTH_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_WIDTH_BYTES-1:0]   s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic                          arm,
    input  logic                          disarm,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [8*DATA_WIDTH_BYTES-1:0] rd_data,
    output logic [DATA_WIDTH_BYTES-1:0]   rd_keep,
    output logic                          rd_last,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          empty,
    output logic                          full,
    output logic [CNT_WIDTH-1:0]          beat_count,
    output logic [CNT_WIDTH-1:0]          pkt_count,
`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
    output logic                          keep_err,
`endif
    output logic                          busy
);
    localparam int DW = 8 * DATA_WIDTH_BYTES;
    localparam int KW = DATA_WIDTH_BYTES;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ARMED, IN_PKT, CLOSING} state_t;

    typedef struct packed {
        logic          last;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          accept, pop;

    // tready is a function of registered state and level only
    assign full          = (level == (AW+1)'(DEPTH));
    assign empty         = (level == '0);
    assign s_axis_tready = (state != IDLE) && !full;
    assign busy          = (state != IDLE);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign pop           = rd_en && !empty;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm && !disarm) state_nxt = ARMED;
            ARMED: begin
                if (disarm)                     state_nxt = (accept && !s_axis_tlast) ? CLOSING : IDLE;
                else if (accept && !s_axis_tlast) state_nxt = IN_PKT;
            end
            IN_PKT: begin
                if (accept && s_axis_tlast) state_nxt = disarm ? IDLE : ARMED;
                else if (disarm)            state_nxt = CLOSING;
            end
            CLOSING: if (accept && s_axis_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Storage has no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (accept && !rst) mem[wr_ptr] <= '{last: s_axis_tlast, keep: s_axis_tkeep, data: s_axis_tdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            beat_count <= '0;
            pkt_count  <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_keep    <= '0;
            rd_last    <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                beat_count <= beat_count + 1'b1;
                if (s_axis_tlast) pkt_count <= pkt_count + 1'b1;
            end
            if (pop) begin
                rd_ptr                      <= rd_ptr + 1'b1;
                {rd_last, rd_keep, rd_data} <= mem[rd_ptr];
            end
            case ({accept, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
    logic [KW-1:0] keep_inc;
    logic          keep_bad;

    // Last beat must be a low-aligned run of ones: keep & (keep+1) == 0
    assign keep_inc = s_axis_tkeep + 1'b1;
    assign keep_bad = (s_axis_tkeep == '0)
                   || (!s_axis_tlast && (s_axis_tkeep != '1))
                   || (s_axis_tlast && ((s_axis_tkeep & keep_inc) != '0));

    always_ff @(posedge clk) begin
        if (rst)                      keep_err <= 1'b0;
        else if (accept && keep_bad)  keep_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_axis_out_capture.sv
// Randomized + directed bench for axis_out_capture against a queue-based behavioural model.
// Build with AXIS_OUT_CAPTURE_KEEP_CHECK_EN to also cover keep_err.
module tb_axis_out_capture;
    localparam int DWB   = 8;
    localparam int DEPTH = 256;
    localparam int CW    = 32;
    localparam int DW    = 8 * DWB;

    typedef struct packed {
        logic           last;
        logic [DWB-1:0] keep;
        logic [DW-1:0]  data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic [DWB-1:0] s_axis_tkeep = '0;
    logic arm = 1'b0, disarm = 1'b0, rd_en = 1'b0;
    logic rd_valid, rd_last, empty, full, busy;
    logic [DW-1:0]  rd_data;
    logic [DWB-1:0] rd_keep;
    logic [$clog2(DEPTH):0] level;
    logic [CW-1:0] beat_count, pkt_count;
`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
    logic keep_err;
`endif

    axis_out_capture #(.DATA_WIDTH_BYTES(DWB), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .arm(arm), .disarm(disarm), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_keep(rd_keep), .rd_last(rd_last),
        .level(level), .empty(empty), .full(full),
        .beat_count(beat_count), .pkt_count(pkt_count),
`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
        .keep_err(keep_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a FIFO queue plus two facts -- "capture enabled" and "inside a packet".
    ent_t        q[$];
    logic        m_cap = 1'b0, m_mid = 1'b0, m_rv = 1'b0, m_acc = 1'b0, m_kerr = 1'b0;
    ent_t        m_rd = '0;
    int unsigned m_beats = 0, m_pkts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic keep_bad(input ent_t b);
        if (b.keep == '0) return 1'b1;
        if (!b.last) return b.keep != '1;
        for (int k = 1; k <= DWB; k++)
            if (int'(b.keep) == (1 << k) - 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_tready();
        return (m_cap || m_mid) && (q.size() < DEPTH);
    endfunction

    task automatic compare();
        chk("tready", 64'(s_axis_tready), 64'(m_tready()));
        chk("level", 64'(level), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("beat_count", 64'(beat_count), 64'(m_beats));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts));
        chk("busy", 64'(busy), 64'(m_cap || m_mid));
        chk("rd_valid", 64'(rd_valid), 64'(m_rv));
        chk("rd_data", rd_data, m_rd.data);
        chk("rd_keep", 64'(rd_keep), 64'(m_rd.keep));
        chk("rd_last", 64'(rd_last), 64'(m_rd.last));
`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
        chk("keep_err", 64'(keep_err), 64'(m_kerr));
`endif
    endtask

    // One clock: drive at negedge, advance model, check at the next negedge.
    task automatic step(input logic v, input ent_t b, input logic a, input logic da,
                        input logic re, input logic r);
        logic tr;
        s_axis_tvalid = v;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        arm = a; disarm = da; rd_en = re; rst = r;
        tr    = m_tready();
        m_acc = 1'b0;
        if (r) begin
            q.delete();
            m_cap = 0; m_mid = 0; m_rv = 0; m_rd = '0;
            m_beats = 0; m_pkts = 0; m_kerr = 0;
        end else begin
            m_acc = v && tr;
            m_rv  = re && (q.size() > 0);
            if (m_rv) m_rd = q.pop_front();
            if (m_acc) begin
                q.push_back(b);
                m_beats++;
                if (b.last) m_pkts++;
                if (keep_bad(b)) m_kerr = 1'b1;
            end
            if (da) m_cap = 1'b0;
            else if (a && !m_cap && !m_mid) m_cap = 1'b1;
            if (m_acc) m_mid = !b.last;
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    function automatic ent_t mk(input logic l, input logic [DWB-1:0] k, input logic [DW-1:0] d);
        ent_t e;
        e.last = l; e.keep = k; e.data = d;
        return e;
    endfunction

    task automatic idle(input logic a, input logic re);
        step(1'b0, '0, a, 1'b0, re, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++) idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
    endtask

    initial begin
        int last_seen, last_idx, sent;
        ent_t hold_b;
        logic holding, v;

        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);

        // 131-beat packet, no reads
        idle(1'b1, 1'b0);
        for (int i = 0; i < 131; i++)
            step(1'b1, mk(i == 130, 8'hFF, 64'hA5A5_0000_0000_0000 | 64'(i)), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("long_beats", 64'(beat_count), 64'd131);
        chk("long_pkts", 64'(pkt_count), 64'd1);
        chk("long_level", 64'(level), 64'd131);
        last_seen = 0; last_idx = -1;
        for (int i = 0; i < 131; i++) begin
            idle(1'b0, 1'b1);
            if (i == 0) chk("first_pop", rd_data, 64'hA5A5_0000_0000_0000);
            if (rd_valid && rd_last) begin last_seen++; last_idx = i; end
        end
        chk("last_count", 64'(last_seen), 64'd1);
        chk("last_index", 64'(last_idx), 64'd130);
        idle(1'b0, 1'b0);

        // Fill to full, then one beat blocked across a pop
        sent = 0;
        for (int t = 0; t < 400 && sent < DEPTH; t++) begin
            step(1'b1, mk(sent % 8 == 7, 8'hFF, 64'h5000 + 64'(sent)), 1'b0, 1'b0, 1'b0, 1'b0);
            if (m_acc) sent++;
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_tready", 64'(s_axis_tready), 64'd0);
        step(1'b1, mk(1'b1, 8'hFF, 64'hBEEF), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("blocked_level", 64'(level), 64'(DEPTH - 1));
        chk("blocked_tready", 64'(s_axis_tready), 64'd1);
        step(1'b1, mk(1'b1, 8'hFF, 64'hBEEF), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("refill_level", 64'(level), 64'(DEPTH));
        drain();

        // disarm on beat 2 of a 5-beat packet
        for (int i = 0; i < 5; i++) begin
            step(1'b1, mk(i == 4, 8'hFF, 64'hD0 + 64'(i)), 1'b0, i == 1, 1'b0, 1'b0);
            if (i == 1) chk("closing_busy", 64'(busy), 64'd1);
        end
        chk("closed_busy", 64'(busy), 64'd0);
        chk("closed_tready", 64'(s_axis_tready), 64'd0);
        step(1'b1, mk(1'b1, 8'hFF, 64'hDEAD), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("closed_level", 64'(level), 64'd5);
        drain();

        // reset mid-packet at level 3
        idle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, mk(1'b0, 8'hFF, 64'hE0 + 64'(i)), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_level", 64'(level), 64'd3);
        step(1'b1, mk(1'b0, 8'hFF, 64'hE3), 1'b0, 1'b0, 1'b0, 1'b1);
        chk("post_rst_level", 64'(level), 64'd0);
        chk("post_rst_beats", 64'(beat_count), 64'd0);
        idle(1'b0, 1'b1);
        chk("post_rst_rdvalid", 64'(rd_valid), 64'd0);

        // simultaneous accept and pop at level 2
        idle(1'b1, 1'b0);
        step(1'b1, mk(1'b0, 8'hFF, 64'h11), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1'b0, 8'hFF, 64'h22), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 8'hFF, 64'h33), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("simul_level", 64'(level), 64'd2);
        chk("simul_rdvalid", 64'(rd_valid), 64'd1);
        chk("simul_rddata", rd_data, 64'h11);
        drain();

`ifdef AXIS_OUT_CAPTURE_KEEP_CHECK_EN
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 1'b0);
        step(1'b1, mk(1'b0, 8'hFF, 64'h1), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, mk(1'b1, 8'h07, 64'h2), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("keep_clean", 64'(keep_err), 64'd0);
        step(1'b1, mk(1'b0, 8'h0F, 64'h3), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("keep_set", 64'(keep_err), 64'd1);
        idle(1'b0, 1'b1);
        chk("keep_held", 64'(keep_err), 64'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // random traffic; a stalled beat is held until accepted
        holding = 1'b0;
        hold_b  = '0;
        for (int t = 0; t < 4000; t++) begin
            logic a, da, re, r;
            ent_t b;
            if (holding) begin
                v = 1'b1; b = hold_b;
            end else begin
                v = ($urandom_range(3) != 0);
                b = mk($urandom_range(5) == 0,
                       ($urandom_range(4) == 0) ? DWB'($urandom) : '1,
                       {$urandom, $urandom});
            end
            a  = ($urandom_range(11) == 0);
            da = ($urandom_range(29) == 0);
            re = ($urandom_range(2) != 0);
            r  = ($urandom_range(499) == 0);
            step(v, b, a, da, re, r);
            holding = v && !m_acc && !r;
            hold_b  = b;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_out_capture.md
Name: axis_out_capture

Overview:
- AXI-Stream sink for the processor output stream (the m_axis side of the tlast-framed processor).
- Accepts beats under tvalid/tready and stores data, tkeep and tlast in a circular buffer.
- Counts beats and packets, and exposes a 1-cycle-latency read port for host/bench readback.
- Capture is gated by arm/disarm control; a packet in flight is never truncated.

Parameters:
- DATA_WIDTH_BYTES, 8, stream tdata width in bytes (tdata = 8*DATA_WIDTH_BYTES bits).
- DEPTH, 256, buffer entries; power of two, >= 4.
- CNT_WIDTH, 32, width of the beat and packet counters.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  source beat valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tdata  in  8*DATA_WIDTH_BYTES  beat data.
- s_axis_tkeep  in  DATA_WIDTH_BYTES  byte-valid mask.
- s_axis_tlast  in  1  last beat of packet.
- arm  in  1  1-cycle pulse: begin capturing.
- disarm  in  1  1-cycle pulse: stop after the current packet.
- rd_en  in  1  pop one entry; ignored when empty.
- rd_valid  out  1  rd_* outputs valid this cycle.
- rd_data  out  8*DATA_WIDTH_BYTES  popped data.
- rd_keep  out  DATA_WIDTH_BYTES  popped tkeep.
- rd_last  out  1  popped tlast.
- level  out  $clog2(DEPTH)+1  entries stored.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- beat_count  out  CNT_WIDTH  accepted beats since reset; wraps.
- pkt_count  out  CNT_WIDTH  accepted tlast beats since reset; wraps.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge) forces:
  - state=IDLE, pointers=0, level=0, empty=1, full=0, s_axis_tready=0.
  - rd_valid=0, rd_data/rd_keep/rd_last=0, beat_count=0, pkt_count=0, busy=0.
- Reset mid-packet discards buffer contents and the partial packet immediately.
- States:
  - IDLE: s_axis_tready=0. arm -> ARMED.
  - ARMED: between packets. s_axis_tready = !full. An accepted beat with tlast=0 -> IN_PKT. An accepted beat with tlast=1 stays in ARMED (single-beat packet). disarm -> IDLE, unless a beat is accepted the same cycle with tlast=0, in which case -> CLOSING.
  - IN_PKT: s_axis_tready = !full. Accepted tlast -> ARMED. disarm -> CLOSING (the same-cycle tlast beat takes priority -> IDLE).
  - CLOSING: s_axis_tready = !full. Accepted tlast -> IDLE. arm is ignored.
- arm and disarm in the same cycle: disarm wins.
- Handshake: a beat is accepted iff tvalid && tready at posedge. tready depends only on registered state and level, never combinationally on tvalid. Source signals must be held while tvalid=1 && tready=0.
- Write: an accepted beat writes {tlast, tkeep, tdata} at wr_ptr; wr_ptr increments modulo DEPTH; beat_count+1; pkt_count+1 if tlast.
- Read: rd_en && !empty at posedge -> the entry at rd_ptr appears on rd_* the next cycle with rd_valid=1 for exactly one cycle; rd_ptr increments modulo DEPTH. rd_en while empty -> rd_valid=0, no state change.
- Between reads, rd_data/rd_keep/rd_last hold the last popped value.
- Level:
  - Updated on write +1 and read -1; simultaneous write and read leave level unchanged.
  - full is computed from registered level, so a write is blocked in a full cycle even if a pop occurs that cycle; tready rises the following cycle.
- Counters wrap from 2^CNT_WIDTH-1 to 0 with no flag.
- Latency: accepted beat -> level/empty update on the next cycle -> earliest rd_valid two cycles after acceptance.

Optional Feature:
- Macro AXIS_OUT_CAPTURE_KEEP_CHECK_EN.
- When defined, adds output port keep_err (1 bit, reset 0, sticky until rst).
- keep_err sets on an accepted beat when:
  - tlast=0 and tkeep is not all-ones, or
  - tlast=1 and tkeep is not contiguous from bit 0 (legal values are 2^k-1, k>=1), or
  - tkeep is zero.
- The offending beat is still stored.
- When not defined, the port and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then arm: send 131 beats, 64-bit, tkeep=0xFF, tlast only on beat 130, with rd_en low and DEPTH=256 -> beat_count=131, pkt_count=1, level=131; pop all -> data in order, rd_last=1 only on entry 130.
- Backpressure, DEPTH=4: send 6 beats continuously with no reads -> tready=0 after 4 accepts, full=1. Pop 1 -> tready returns the next cycle, beat 5 accepted; no beat lost or duplicated.
- disarm asserted on beat 2 of a 5-beat packet -> beats 3..5 still accepted, state CLOSING then IDLE after tlast, tready=0 afterwards, pkt_count=1.
- rst asserted mid-packet with level=3 -> next cycle level=0, empty=1, counters=0, state IDLE, tready=0; rd_en produces no rd_valid.
- Simultaneous accept and pop at level=2 -> level stays 2, rd_valid=1 next cycle carrying the oldest entry.
- With KEEP_CHECK_EN: non-last beat with tkeep=0x0F -> keep_err=1 the next cycle and held; last beat with tkeep=0x07 on a clean run -> keep_err stays 0.
